// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg: shared opcodes, FSM state type and byte-enable helper for lsu_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Halfword ops are decoded here unconditionally; legality is decided by the caller.
  function automatic logic [3:0] calc_be(input logic [5:0] op, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      OP_LW, OP_SW:          be = 4'b1111;
      OP_LB, OP_LBU, OP_SB:  be = 4'b0001 << lane;
      OP_LH, OP_LHU, OP_SH:  be = lane[1] ? 4'b1100 : 4'b0011;
      default:               be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// lsu_load_align: selects the addressed byte/halfword of a memory word and
// sign- or zero-extends it according to the load opcode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_b = rdata[7:0];
      2'd1:    sel_b = rdata[15:8];
      2'd2:    sel_b = rdata[23:16];
      default: sel_b = rdata[31:24];
    endcase
    sel_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (op)
      OP_LB:   data = {{24{sel_b[7]}}, sel_b};
      OP_LBU:  data = {24'h000000, sel_b};
      OP_LH:   data = {{16{sel_h[15]}}, sel_h};
      OP_LHU:  data = {16'h0000, sel_h};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl: load/store unit driving a req/gnt/rvalid data-memory port.
// Define LSU_HALF_EN to enable the lh/lhu/sh halfword operations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [5:0]  cpu_op,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state;
  lsu_state_t  state_nxt;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic        is_word;
  logic        is_byte;
  logic        is_half;
  logic        is_store;
  logic        legal;
  logic        aligned;
  logic        start_ok;
  logic        start_err;
  logic [31:0] wdata_fmt;
  logic [31:0] load_data;

  always_comb begin
    is_word = (cpu_op == OP_LW) || (cpu_op == OP_SW);
    is_byte = (cpu_op == OP_LB) || (cpu_op == OP_LBU) || (cpu_op == OP_SB);
`ifdef LSU_HALF_EN
    is_half = (cpu_op == OP_LH) || (cpu_op == OP_LHU) || (cpu_op == OP_SH);
`else
    is_half = 1'b0;
`endif
    is_store  = (cpu_op == OP_SW) || (cpu_op == OP_SB) || (cpu_op == OP_SH);
    legal     = is_word || is_byte || is_half;
    aligned   = is_word ? (cpu_addr[1:0] == 2'b00) :
                is_half ? ~cpu_addr[0] : 1'b1;
    start_ok  = (state == IDLE) && cpu_req && legal && aligned;
    start_err = (state == IDLE) && cpu_req && !(legal && aligned);

    // Narrow stores replicate the datum across every lane so the byte enables alone pick it.
    if (is_byte)
      wdata_fmt = {4{cpu_wdata[7:0]}};
    else if (is_half)
      wdata_fmt = {2{cpu_wdata[15:0]}};
    else
      wdata_fmt = cpu_wdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok)
          state_nxt = REQ;
        else if (start_err)
          state_nxt = RESP;
      end
      REQ: begin
        if (mem_gnt)
          state_nxt = mem_we ? RESP : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 6'd0;
      lane_q    <= 2'd0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 10'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else begin
      cpu_done <= (state_nxt == RESP);
      cpu_err  <= start_err;

      if (start_ok) begin
        op_q      <= cpu_op;
        lane_q    <= cpu_addr[1:0];
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= cpu_addr[11:2];
        mem_be    <= calc_be(cpu_op, cpu_addr[1:0]);
        mem_wdata <= wdata_fmt;
      end else if ((state == REQ) && mem_gnt) begin
        // Request phase is over; park the bus at zero until the next access.
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= 10'd0;
        mem_be    <= 4'd0;
        mem_wdata <= 32'd0;
      end

      if ((state == WAIT_R) && mem_rvalid)
        cpu_rdata <= load_data;
    end
  end

  assign cpu_busy = (state != IDLE);

  lsu_load_align u_load_align (
    .op      (op_q),
    .addr_lo (lane_q),
    .rdata   (mem_rdata),
    .data    (load_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// tb_lsu_ctrl: directed and randomized bench for lsu_ctrl with a memory
// responder and a transaction-level reference model (honours LSU_HALF_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_SH  = 6'b101001;

  localparam int PH_IDLE = 0;
  localparam int PH_GNT  = 1;
  localparam int PH_RV   = 2;
  localparam int PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [5:0]  cpu_op = 6'd0;
  logic [11:0] cpu_addr = 12'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_op     (cpu_op),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- memory responder (stimulus) ----------------
  logic [31:0] slave_mem [0:1023];
  int          gnt_wait = 0;
  int          rv_wait  = 0;
  logic        noise_en = 1'b0;
  logic        stray_rv = 1'b0;
  int          g_cnt    = 0;
  int          rv_cnt   = 0;
  logic        rd_pend  = 1'b0;
  logic [9:0]  rd_addr  = 10'd0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (!rst_n) begin
      rd_pend = 1'b0;
      g_cnt   = 0;
    end else begin
      if (rd_pend) begin
        if (rv_cnt >= rv_wait) begin
          mem_rvalid = 1'b1;
          mem_rdata  = slave_mem[rd_addr];
          rd_pend    = 1'b0;
        end else begin
          rv_cnt++;
        end
      end else if (stray_rv || (noise_en && !mem_req && $urandom_range(0, 3) == 0)) begin
        mem_rvalid = 1'b1;
      end
      if (mem_req) begin
        if (g_cnt >= gnt_wait) begin
          mem_gnt = 1'b1;
          g_cnt   = 0;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) slave_mem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
          end else begin
            rd_pend = 1'b1;
            rd_addr = mem_addr;
            rv_cnt  = 0;
          end
        end else begin
          g_cnt++;
        end
      end else if (noise_en && $urandom_range(0, 3) == 0) begin
        mem_gnt = 1'b1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] model_mem [0:1023];
  int          ph = PH_IDLE;
  logic        m_err = 1'b0;
  logic        m_store = 1'b0;
  logic        m_signed = 1'b0;
  int          m_sz = 0;
  logic [11:0] m_addr = 12'd0;
  logic [3:0]  m_be = 4'd0;
  logic [31:0] m_wd = 32'd0;
  logic [31:0] exp_rdata = 32'd0;

  function automatic int m_size(input logic [5:0] op);
    case (op)
      T_LW, T_SW:        return 4;
      T_LB, T_LBU, T_SB: return 1;
`ifdef LSU_HALF_EN
      T_LH, T_LHU, T_SH: return 2;
`endif
      default:           return 0;
    endcase
  endfunction

  task automatic model_accept(input logic [5:0] op, input logic [11:0] addr, input logic [31:0] wd);
    int a;
    a        = int'(addr);
    m_sz     = m_size(op);
    m_addr   = addr;
    m_store  = (op == T_SW) || (op == T_SB) || (op == T_SH);
    m_signed = (op == T_LB) || (op == T_LH);
    if (m_sz == 0)
      m_err = 1'b1;
    else
      m_err = (a % m_sz) != 0;
    if (m_err) begin
      ph = PH_DONE;
    end else begin
      m_be = 4'(((1 << m_sz) - 1) << (a % 4));
      for (int i = 0; i < 4; i++)
        m_wd[8*i +: 8] = wd[8*(i % m_sz) +: 8];
      ph = PH_GNT;
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input int lane,
                                             input int sz, input logic sgn);
    logic [31:0] v;
    logic [31:0] mask;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    v    = (word >> (8*lane)) & mask;
    if (sgn && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        = PH_IDLE;
      exp_rdata = 32'd0;
    end else begin
      case (ph)
        PH_IDLE: if (cpu_req) model_accept(cpu_op, cpu_addr, cpu_wdata);
        PH_GNT: begin
          if (mem_gnt) begin
            if (m_store) begin
              for (int i = 0; i < 4; i++)
                if (m_be[i]) model_mem[m_addr[11:2]][8*i +: 8] = m_wd[8*i +: 8];
              ph = PH_DONE;
            end else begin
              ph = PH_RV;
            end
          end
        end
        PH_RV: begin
          if (mem_rvalid) begin
            exp_rdata = model_load(model_mem[m_addr[11:2]], int'(m_addr[1:0]), m_sz, m_signed);
            ph = PH_DONE;
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cpu_busy", 32'(cpu_busy), 32'(ph != PH_IDLE));
      check("cpu_done", 32'(cpu_done), 32'(ph == PH_DONE));
      check("cpu_err", 32'(cpu_err), 32'((ph == PH_DONE) && m_err));
      check("mem_req", 32'(mem_req), 32'(ph == PH_GNT));
      check("cpu_rdata", cpu_rdata, exp_rdata);
      if (ph == PH_GNT) begin
        check("mem_we", 32'(mem_we), 32'(m_store));
        check("mem_addr", 32'(mem_addr), 32'(m_addr[11:2]));
        check("mem_be", 32'(mem_be), 32'(m_be));
        if (m_store) check("mem_wdata", mem_wdata, m_wd);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [5:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input int pulse_at, input int extra,
                        output int lat, output logic err, output int req_cycles,
                        output logic we1, output logic [9:0] ad1,
                        output logic [3:0] be1, output logic [31:0] wd1);
    int k;
    int dones;
    cpu_op     = op;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    cpu_req    = 1'b1;
    lat        = -1;
    err        = 1'b0;
    req_cycles = 0;
    dones      = 0;
    k          = 0;
    we1 = 1'b0; ad1 = 10'd0; be1 = 4'd0; wd1 = 32'd0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cpu_req = 1'b0;
        we1 = mem_we; ad1 = mem_addr; be1 = mem_be; wd1 = mem_wdata;
      end
      if (pulse_at > 0 && k == pulse_at) begin
        cpu_req  = 1'b1;
        cpu_op   = T_LW;
        cpu_addr = 12'h010;
      end
      if (pulse_at > 0 && k == pulse_at + 1) cpu_req = 1'b0;
      if (mem_req) req_cycles++;
      if (cpu_done) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          err = cpu_err;
        end
      end
      if (lat >= 0 && k >= lat + 1 + extra) break;
    end
    check("done_pulses", 32'(dones), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          reqc;
    int          dn;
    logic        er;
    logic        we1;
    logic [9:0]  ad1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] v;
    logic [5:0]  rop;
    logic [5:0]  op_tab [0:7];

    op_tab[0] = T_LW; op_tab[1] = T_LB; op_tab[2] = T_LBU; op_tab[3] = T_SW;
    op_tab[4] = T_SB; op_tab[5] = T_LH; op_tab[6] = T_LHU; op_tab[7] = T_SH;

    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      model_mem[i] = v;
      slave_mem[i] = v;
    end
    model_mem[4] = 32'h80F0_12A5;
    slave_mem[4] = 32'h80F0_12A5;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_req, mem_we}), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Directed loads from word 0x004 = 0x80F0_12A5 with zero-wait memory.
    run_op(T_LB, 12'h013, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("lb_rdata", cpu_rdata, 32'hFFFF_FF80);
    check("lb_err", 32'(er), 32'd0);
    check("lb_latency", 32'(lat), 32'd3);
    run_op(T_LBU, 12'h011, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("lbu_rdata", cpu_rdata, 32'h0000_0012);
    run_op(T_LW, 12'h010, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("lw_rdata", cpu_rdata, 32'h80F0_12A5);
    check("lw_err", 32'(er), 32'd0);
    check("lw_latency", 32'(lat), 32'd3);

    run_op(T_LH, 12'h012, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
`ifdef LSU_HALF_EN
    check("lh_be", 32'(be1), 32'(4'b1100));
    check("lh_rdata", cpu_rdata, 32'hFFFF_80F0);
    check("lh_err", 32'(er), 32'd0);
`else
    check("lh_err", 32'(er), 32'd1);
    check("lh_latency", 32'(lat), 32'd1);
    check("lh_rdata_held", cpu_rdata, 32'h80F0_12A5);
`endif

    run_op(T_SB, 12'h012, 32'h1234_56CC, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("sb_we", 32'(we1), 32'd1);
    check("sb_addr", 32'(ad1), 32'h004);
    check("sb_be", 32'(be1), 32'(4'b0100));
    check("sb_wdata", wd1, 32'hCCCC_CCCC);
    check("sb_latency", 32'(lat), 32'd2);
    run_op(T_LW, 12'h010, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("lw_after_sb", cpu_rdata, 32'h80CC_12A5);

    run_op(T_LW, 12'h012, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("mis_err", 32'(er), 32'd1);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_no_req", 32'(reqc), 32'd0);
    check("mis_rdata_held", cpu_rdata, 32'h80CC_12A5);

    // Backpressure: grant withheld 3 cycles, stray cpu_req while busy.
    gnt_wait = 3;
    run_op(T_SW, 12'h020, 32'hA5A5_0F0F, 2, 3, lat, er, reqc, we1, ad1, be1, wd1);
    check("bp_req_cycles", 32'(reqc), 32'd4);
    check("bp_latency", 32'(lat), 32'd5);
    gnt_wait = 0;

    // Reset while waiting for read data.
    rv_wait  = 10;
    cpu_op   = T_LW;
    cpu_addr = 12'h010;
    cpu_req  = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_req, mem_we}), 32'd0);
    check("arst_rdata", cpu_rdata, 32'd0);
    check("arst_mem", {mem_wdata[31:14], mem_be, mem_addr}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rv_wait = 0;
    @(negedge clk);
    #2 stray_rv = 1'b1;
    @(negedge clk);
    #2 stray_rv = 1'b0;
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done) dn++;
    end
    check("stray_rv_done", 32'(dn), 32'd0);
    check("stray_rv_rdata", cpu_rdata, 32'd0);
    run_op(T_LW, 12'h010, 32'd0, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    check("post_rst_lw", cpu_rdata, 32'h80CC_12A5);
    check("post_rst_latency", 32'(lat), 32'd3);

    // Randomized traffic over a small window so stores and loads overlap.
    noise_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      gnt_wait = $urandom_range(0, 3);
      rv_wait  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0)
        rop = 6'($urandom);
      else
        rop = op_tab[$urandom_range(0, 7)];
      run_op(rop, 12'($urandom_range(0, 63)), $urandom, 0, 0, lat, er, reqc, we1, ad1, be1, wd1);
    end
    noise_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit that sits between the CPU datapath and the 4 KB data memory port and acts as the initiator of every data-memory transaction. It accepts one load or store from the core, checks alignment, builds the word address, byte enables and lane-replicated write data, runs a req/gnt/rvalid handshake with memory, and returns sign- or zero-extended load data. It replaces direct datapath-to-memory wiring so memories with wait states can be used.

## Interface
- No parameters. Address width is fixed at 12 bits (4 KB); data width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_op  in  6  MIPS opcode: lw 100011, lb 100000, lbu 100100, sw 101011, sb 101000.
- cpu_addr  in  12  byte address.
- cpu_wdata  in  32  store data; byte stores use bits [7:0].
- cpu_busy  out  1  high in every state except IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; 1 = misaligned or illegal op.
- cpu_rdata  out  32  load result; updated only by a successful load, otherwise held.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  10  word address, cpu_addr[11:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

## Operation
- States:
  - IDLE: cpu_req=1 latches op/addr/wdata and decodes the request.
    - Legal and aligned -> REQ.
    - Illegal op or misaligned -> RESP with err=1; no memory access.
  - REQ: on mem_gnt=1, a store -> RESP and a load -> WAIT_R.
  - WAIT_R: on mem_rvalid=1, capture the extracted data -> RESP.
  - RESP: cpu_done=1 -> IDLE.
- Alignment: word ops need addr[1:0]=00; byte ops are always aligned.
- Byte enables: sw and lw use 1111; sb, lb and lbu use 1 << addr[1:0].
- Write data: sw passes wdata through unchanged; sb replicates {4{wdata[7:0]}}.
- Load extraction: the selected byte = mem_rdata[8*addr[1:0]+7 : 8*addr[1:0]].
  - lb sign-extends it to 32 bits.
  - lbu zero-extends it to 32 bits.
  - lw uses the full word.
- A cpu_req outside IDLE is ignored; the core must wait for !cpu_busy.
- mem_rvalid outside WAIT_R and mem_gnt outside REQ are ignored.

## Timing
- Reset values: all outputs 0, cpu_rdata = 0, state = IDLE. Reset asserted mid-transaction drops the transaction; no done pulse is produced.
- Accept at cycle T; mem_req and all mem_* outputs are registered and valid from T+1.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata hold stable through the cycle in which mem_gnt is sampled high. mem_req drops the cycle after the grant.
- Store: grant in cycle G gives cpu_done in G+1. Minimum latency is 2 cycles after accept.
- Load: mem_rvalid may arrive no earlier than G+1. rvalid in cycle R gives cpu_done and the new cpu_rdata in R+1. Minimum latency is 3 cycles.
- Error: cpu_done and cpu_err in T+1.
- cpu_err is 0 whenever cpu_done is 0.
- There is no timeout; the block waits indefinitely for gnt and rvalid.

## Configuration
- LSU_HALF_EN defined: adds the halfword ops.
  - Opcodes: lh 100001, lhu 100101, sh 101001.
  - Alignment: addr[0]=0.
  - Byte enables: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - sh write data: {2{wdata[15:0]}}.
  - lh sign-extends the selected halfword; lhu zero-extends it.
- LSU_HALF_EN undefined: those opcodes are illegal and return cpu_err=1 with no memory access.

## Structure
- Package lsu_pkg holds:
  - the opcode localparams (including the halfword ones);
  - the state enum (IDLE, REQ, WAIT_R, RESP);
  - a function computing byte enables from op and addr[1:0].
- One combinational sub-module, lsu_load_align, takes op, addr[1:0] and mem_rdata and produces the extended 32-bit result. It is instantiated once in lsu_ctrl.

## Test plan
- Memory word 0x004 (byte address 0x010) = 0x80F0_12A5, one-cycle gnt. lb at 0x013 -> cpu_rdata = 0xFFFF_FF80; lbu at 0x011 -> 0x0000_0012; lw at 0x010 -> 0x80F0_12A5, cpu_err=0.
- sb at 0x012 with wdata 0x1234_56CC -> mem_we=1, mem_addr=0x004, mem_be=0100, mem_wdata=0xCCCC_CCCC. A following lw at 0x010 -> 0x80CC_12A5.
- lw at 0x012 -> mem_req never rises; cpu_done and cpu_err=1 at T+1; cpu_rdata unchanged.
- Backpressure: gnt held low for 3 cycles -> mem_req and mem_* stay stable for 4 cycles; exactly one cpu_done pulse; a cpu_req pulsed during busy is ignored.
- Reset pulse while in WAIT_R -> all outputs 0 immediately, no cpu_done; a later rvalid is ignored; the next lw completes normally.
- Opcode 100001 (lh) at 0x012 -> with LSU_HALF_EN: mem_be=1100, cpu_rdata = 0xFFFF_80F0; without it: cpu_err=1.
